// File: rtl/rr_bus_arbiter.sv
// Registered round-robin arbiter and master mux for the shared system bus.
// Define BUS_ARB_TIMEOUT_EN to add forced revoke of owners starved of bus_ready.
module rr_bus_arbiter #(
  parameter int NREQ    = 8,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    bus_req,
  output logic [NREQ-1:0]    bus_ack,
  input  logic [NREQ*32-1:0] m_addr,
  input  logic [NREQ*32-1:0] m_wdata,
  input  logic [NREQ-1:0]    m_rd,
  input  logic [NREQ-1:0]    m_wr,
  output logic [31:0]        bus_addr,
  output logic [31:0]        bus_wdata,
  output logic               bus_rd,
  output logic               bus_wr,
  input  logic               bus_ready,
  output logic [NREQ-1:0]    m_ready,
  output logic               owner_valid,
  output logic [2:0]         owner_id,
  output logic               timeout
);

  // state | meaning
  // IDLE  | no grant; arbitrate among eligible requests from ptr+1 upward
  // OWNED | owner_id holds the bus until its request drops (or is revoked)
  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state, state_nxt;
  logic [2:0]      owner_nxt;
  logic [2:0]      ptr, ptr_nxt;
  logic [2:0]      pick, idx;
  logic            found;
  logic [NREQ-1:0] eligible;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0] mask, mask_nxt;
  logic            timeout_nxt;

  // A revoked master stays masked until it lets go of its request.
  assign eligible = bus_req & ~mask;
`else
  assign eligible = bus_req;
  assign timeout  = 1'b0;
`endif

  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = 3'((int'(ptr) + i) % NREQ);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_id;
    ptr_nxt   = ptr;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_nxt     = cnt;
    mask_nxt    = mask & bus_req;
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = OWNED;
          owner_nxt = pick;
          ptr_nxt   = pick;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end
      OWNED: begin
        if (!bus_req[owner_id]) begin
          state_nxt = IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        // ptr already equals the owner, so the next scan starts past it.
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state_nxt          = IDLE;
          timeout_nxt        = 1'b1;
          mask_nxt[owner_id] = 1'b1;
        end else if (bus_ready) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner_id <= '0;
      ptr      <= 3'(NREQ - 1);
`ifdef BUS_ARB_TIMEOUT_EN
      cnt      <= '0;
      mask     <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      owner_id <= owner_nxt;
      ptr      <= ptr_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt      <= cnt_nxt;
      mask     <= mask_nxt;
      timeout  <= timeout_nxt;
`endif
    end
  end

  assign owner_valid = (state == OWNED);

  always_comb begin
    bus_ack = '0;
    if (owner_valid) bus_ack[owner_id] = 1'b1;
  end

  assign m_ready   = bus_ack & {NREQ{bus_ready}};
  assign bus_addr  = owner_valid ? m_addr[int'(owner_id)*32 +: 32] : '0;
  assign bus_wdata = owner_valid ? m_wdata[int'(owner_id)*32 +: 32] : '0;
  assign bus_rd    = owner_valid & m_rd[owner_id];
  assign bus_wr    = owner_valid & m_wr[owner_id];

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Registered round-robin arbiter and master multiplexer for the shared system bus between the instruction cache, block RAM and future bus masters. It grants one requester at a time and holds the grant until the owner drops its request. It steers the owner's address, write data and strobes onto the shared bus and routes `bus_ready` back only to the owner. It replaces the combinational fixed-priority arbitration on the 8-bit `bus_req`/`bus_ack` vectors.

## Interface
Parameters:
- `NREQ`, 8: number of requesters; index 0 is the instruction cache.
- `TIMEOUT`, 256: cycles without `bus_ready` before forced revoke. Used only with `BUS_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `bus_req`  in  NREQ: per-master request; held high for the whole ownership.
- `bus_ack`  out  NREQ: one-hot or zero grant, registered.
- `m_addr`  in  NREQ*32: master addresses; master i occupies bits [32i+31:32i].
- `m_wdata`  in  NREQ*32: master write data, same packing as `m_addr`.
- `m_rd`, `m_wr`  in  NREQ each: master read and write strobes.
- `bus_addr`, `bus_wdata`  out  32 each: the owner's values, 0 when there is no owner.
- `bus_rd`, `bus_wr`  out  1 each: the owner's strobes, forced 0 when there is no owner.
- `bus_ready`  in  1: slave completion for the current beat.
- `m_ready`  out  NREQ: `bus_ready` gated to the owner's bit only.
- `owner_valid`  out  1: a grant is active.
- `owner_id`  out  3: index of the current owner, or of the last owner when idle.
- `timeout`  out  1: one-cycle pulse on forced revoke.

## Operation
- State machine with two states, IDLE and OWNED; reset enters IDLE.
- IDLE, any `bus_req` high: choose the first requester scanning upward from `ptr+1`, wrapping modulo NREQ. Then set `owner_id`, set `bus_ack[owner]`, move to OWNED, and set `ptr` to the owner.
- IDLE, no request: stay in IDLE; outputs stay zero.
- OWNED, `bus_req[owner]` high: stay in OWNED and keep the grant, regardless of other requests.
- OWNED, `bus_req[owner]` low: clear `bus_ack` and return to IDLE. There is always at least one IDLE cycle between owners (turnaround).
- Requests from non-owners are ignored while OWNED; they stay pending at their masters.
- Multiplexing is combinational from the registered owner. `bus_rd`, `bus_wr`, `bus_addr` and `bus_wdata` are zero whenever `owner_valid` is 0.
- `m_ready[i] = bus_ready & owner_valid & (owner_id == i)`.
- `ptr` resets to NREQ-1, so requester 0 wins the first arbitration after reset.
- Reset values: `bus_ack` = 0, `owner_valid` = 0, `owner_id` = 0, `timeout` = 0, `ptr` = NREQ-1, all bus outputs 0.
- Asserting `rst` mid-transaction drops the grant immediately (asynchronous). The in-flight slave access is abandoned; the slave sees `bus_rd`/`bus_wr` = 0.

## Timing
- Grant latency from IDLE: `bus_req` sampled high at edge N makes `bus_ack` high after edge N, usable in cycle N+1.
- Release: owner's request low at edge M causes `bus_ack` low after M. The earliest next grant follows edge M+1.
- Worst-case wait for requester i is NREQ-1 full ownerships plus the turnaround cycles.
- A master that drops its request and reasserts it in the next cycle is last in round-robin order if others are pending.
- An owner's request and `bus_ready` may fall in the same cycle. `m_ready` is still delivered that cycle, and the release happens at the edge.

## Configuration
- Macro: `BUS_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A ceil(log2(TIMEOUT+1))-bit counter clears on grant and on every `bus_ready`, and increments each OWNED cycle otherwise.
  - When the counter equals TIMEOUT-1 in OWNED, the next edge clears `bus_ack`, enters IDLE, advances `ptr` past the owner, and pulses `timeout` for one cycle.
  - The revoked master must drop and reassert its request before it can be granted again; its stale request is masked until it goes low.
- Without the macro: no counter and no mask; `timeout` is tied to 0; ownership is unbounded.

## Test plan
- Reset, then `bus_req` = 8'h01: `bus_ack` = 8'h01 one cycle later; `bus_addr` equals `m_addr[31:0]`.
- `bus_req` = 8'h05 held constantly from IDLE with `ptr` = 7, each owner holding for 4 cycles and dropping for 1:
  - grants alternate 0, 2, 0, 2;
  - exactly one IDLE cycle between grants.
- Owner 2 active and `bus_ready` pulsed: `m_ready` = 8'h04 only; `bus_rd`/`bus_wr` follow `m_rd[2]`/`m_wr[2]`; bus outputs are 0 during IDLE.
- All 8 requesting with `ptr` = 3: grant order is 4, 5, 6, 7, 0, 1, 2, 3.
- `rst` pulsed while owner 1 is mid-read: `bus_ack` = 0 and `bus_rd` = 0 asynchronously. After release, with `bus_req` = 8'h02 | 8'h01, the grant goes to 0 first.
- With `BUS_ARB_TIMEOUT_EN` and TIMEOUT = 16, owner 3 holds its request with no `bus_ready`:
  - `timeout` pulses after 16 OWNED cycles and `bus_ack` goes 0;
  - pending requester 4 is granted next;
  - 3 is not regranted until its request toggles.
